// File: rtl/iic_share_pkg.sv
// Shared encodings for the two-requester IIC arbiter: core call codes,
// arbiter FSM states and the watchdog counter width.
package iic_share_pkg;

   localparam logic [1:0] CALL_NONE = 2'b00;
   localparam logic [1:0] CALL_RD   = 2'b01;
   localparam logic [1:0] CALL_WR   = 2'b10;
   localparam logic [1:0] CALL_BAD  = 2'b11;

   localparam int WDOG_W = 20;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALL,
      ST_FINISH,
      ST_GAP
   } state_t;

   typedef enum logic {
      GRANT_A,
      GRANT_B
   } grant_t;

   function automatic logic isRequesting(input logic [1:0] call);
      return call != CALL_NONE;
   endfunction

endpackage

// File: rtl/iic_share_wdog.sv
// Up-counter shared by the transaction watchdog and the bus-free gap timer.
// oTerm flags that the count has reached the currently selected terminal value.
module iic_share_wdog
   import iic_share_pkg::*;
#(
   parameter int W = WDOG_W
) (
   input  logic         CLOCK,
   input  logic         RST_n,
   input  logic         iClear,
   input  logic         iEnable,
   input  logic [W-1:0] iTerm,
   output logic         oTerm
);

   logic [W-1:0] count;

   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         count <= '0;
      end else if (iClear) begin
         count <= '0;
      end else if (iEnable) begin
         count <= count + 1'b1;
      end
   end

   assign oTerm = (count == iTerm);

endmodule

// File: rtl/iic_share_arb.sv
// Shares one iic byte-transfer core between requester A (OLED) and requester B
// (RTC) with round-robin grant, per-device addressing, watchdog and bus-free gap.
module iic_share_arb
   import iic_share_pkg::*;
#(
   parameter logic [7:0]  DEV_A   = 8'h78,
   parameter logic [7:0]  DEV_B   = 8'hA2,
   parameter int          GAP     = 16,
   parameter logic [19:0] TIMEOUT = 20'd1_000_000
) (
   input  logic         CLOCK,
   input  logic         RST_n,
   input  logic [1:0]   iCallA,
   input  logic [7:0]   iAddrA,
   input  logic [7:0]   iDataA,
   output logic         oDoneA,
   output logic         oErrA,
   output logic [7:0]   oDataA,
   input  logic [1:0]   iCallB,
   input  logic [7:0]   iAddrB,
   input  logic [7:0]   iDataB,
   output logic         oDoneB,
   output logic         oErrB,
   output logic [7:0]   oDataB,
   output logic [1:0]   oCall,
   output logic [7:0]   oDev,
   output logic [7:0]   oAddr,
   output logic [7:0]   oData,
   input  logic         iDone,
   input  logic [7:0]   iData,
   output logic         oBusy,
   output state_t       oState
);

   state_t      state;
   grant_t      lastGrant;
   grant_t      owner;
   logic [1:0]  callReg;
   logic [7:0]  readByte;
   logic        err;

   logic        reqA;
   logic        reqB;
   logic        pickB;
   logic [1:0]  grantCall;
   logic        wdogClear;
   logic        wdogEnable;
   logic [WDOG_W-1:0] wdogTerm;
   logic        wdogTc;

   // On a tie, B wins only when A held the previous grant.
   always_comb begin
      reqA       = isRequesting(iCallA);
      reqB       = isRequesting(iCallB);
      pickB      = reqB && (!reqA || (lastGrant == GRANT_A));
      grantCall  = pickB ? iCallB : iCallA;
      wdogClear  = (state == ST_IDLE) || (state == ST_FINISH);
      wdogEnable = (state == ST_CALL) || (state == ST_GAP);
      wdogTerm   = (state == ST_GAP) ? WDOG_W'(GAP) : (TIMEOUT - 20'd1);
   end

   iic_share_wdog #(.W(WDOG_W)) u_wdog (
      .CLOCK   (CLOCK),
      .RST_n   (RST_n),
      .iClear  (wdogClear),
      .iEnable (wdogEnable),
      .iTerm   (wdogTerm),
      .oTerm   (wdogTc)
   );

   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         state     <= ST_IDLE;
         lastGrant <= GRANT_B;
         owner     <= GRANT_A;
         callReg   <= CALL_NONE;
         readByte  <= 8'h00;
         err       <= 1'b0;
         oCall     <= CALL_NONE;
         oDev      <= 8'h00;
         oAddr     <= 8'h00;
         oData     <= 8'h00;
         oDoneA    <= 1'b0;
         oErrA     <= 1'b0;
         oDataA    <= 8'h00;
         oDoneB    <= 1'b0;
         oErrB     <= 1'b0;
         oDataB    <= 8'h00;
         oBusy     <= 1'b0;
      end else begin
         oDoneA <= 1'b0;
         oErrA  <= 1'b0;
         oDoneB <= 1'b0;
         oErrB  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (reqA || reqB) begin
                  owner     <= pickB ? GRANT_B : GRANT_A;
                  lastGrant <= pickB ? GRANT_B : GRANT_A;
                  callReg   <= grantCall;
                  oDev      <= pickB ? DEV_B : DEV_A;
                  oAddr     <= pickB ? iAddrB : iAddrA;
                  oData     <= pickB ? iDataB : iDataA;
                  oBusy     <= 1'b1;
                  // An illegal call never reaches the core.
                  if (grantCall == CALL_BAD) begin
                     err   <= 1'b1;
                     state <= ST_FINISH;
                  end else begin
                     err   <= 1'b0;
                     state <= ST_CALL;
                  end
               end
            end
            ST_CALL: begin
               if (iDone) begin
                  if (callReg == CALL_RD) readByte <= iData;
                  oCall <= CALL_NONE;
                  err   <= 1'b0;
                  state <= ST_FINISH;
               end else if (wdogTc) begin
                  oCall <= CALL_NONE;
                  err   <= 1'b1;
                  state <= ST_FINISH;
               end else begin
                  oCall <= callReg;
               end
            end
            ST_FINISH: begin
               if (owner == GRANT_A) begin
                  oDoneA <= 1'b1;
                  oErrA  <= err;
                  if ((callReg == CALL_RD) && !err) oDataA <= readByte;
               end else begin
                  oDoneB <= 1'b1;
                  oErrB  <= err;
                  if ((callReg == CALL_RD) && !err) oDataB <= readByte;
               end
               state <= ST_GAP;
            end
            ST_GAP: begin
               if (wdogTc) begin
                  oBusy <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign oState = state;

endmodule

// File: tb/tb_iic_share_arb.sv
// Directed bench for iic_share_arb: write, read, round-robin, timeout,
// illegal call and asynchronous reset during a transaction.
module tb_iic_share_arb;
   import iic_share_pkg::*;

   localparam int          GAP_C = 16;
   localparam logic [19:0] TMO_C = 20'd100;

   logic        CLOCK = 1'b0;
   logic        RST_n = 1'b0;
   logic [1:0]  iCallA = 2'b00, iCallB = 2'b00;
   logic [7:0]  iAddrA = 8'h00, iDataA = 8'h00, iAddrB = 8'h00, iDataB = 8'h00;
   logic        iDone = 1'b0;
   logic [7:0]  iData = 8'h00;
   logic        oDoneA, oErrA, oDoneB, oErrB, oBusy;
   logic [7:0]  oDataA, oDataB, oDev, oAddr, oData;
   logic [1:0]  oCall;
   state_t      oState;

   int checks = 0;
   int errors = 0;

   always #5 CLOCK = ~CLOCK;

   iic_share_arb #(.DEV_A(8'h78), .DEV_B(8'hA2), .GAP(GAP_C), .TIMEOUT(TMO_C)) dut (
      .CLOCK(CLOCK), .RST_n(RST_n),
      .iCallA(iCallA), .iAddrA(iAddrA), .iDataA(iDataA),
      .oDoneA(oDoneA), .oErrA(oErrA), .oDataA(oDataA),
      .iCallB(iCallB), .iAddrB(iAddrB), .iDataB(iDataB),
      .oDoneB(oDoneB), .oErrB(oErrB), .oDataB(oDataB),
      .oCall(oCall), .oDev(oDev), .oAddr(oAddr), .oData(oData),
      .iDone(iDone), .iData(iData), .oBusy(oBusy), .oState(oState)
   );

   task automatic tick;
      @(negedge CLOCK);
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      while (oBusy && n < 100) begin
         tick;
         n++;
      end
      checks++;
      if (oBusy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: oBusy=%b after %0d cycles, required 0", oBusy, n);
      end
   endtask

   task automatic test_reset;
      repeat (2) tick;
      checks++;
      if (oCall !== 2'b00) begin errors++; $display("FAIL rst_call: got %b, required 00", oCall); end
      checks++;
      if (oBusy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", oBusy); end
      checks++;
      if ({oDev, oAddr, oData} !== 24'h0) begin
         errors++; $display("FAIL rst_bus: got %h, required 000000", {oDev, oAddr, oData});
      end
      checks++;
      if ({oDoneA, oErrA, oDoneB, oErrB} !== 4'b0) begin
         errors++; $display("FAIL rst_done: got %b, required 0000", {oDoneA, oErrA, oDoneB, oErrB});
      end
      checks++;
      if ({oDataA, oDataB} !== 16'h0) begin
         errors++; $display("FAIL rst_data: got %h, required 0000", {oDataA, oDataB});
      end
      RST_n = 1'b1;
      tick;
      checks++;
      if ({oBusy, oCall} !== 3'b000) begin
         errors++; $display("FAIL rst_release_idle: got %b, required 000", {oBusy, oCall});
      end
   endtask

   task automatic test_write_a;
      int n;
      iCallA = CALL_WR; iAddrA = 8'h00; iDataA = 8'hAE;
      tick;
      checks++;
      if ({oBusy, oCall} !== 3'b100) begin
         errors++; $display("FAIL wr_grant: busy/call got %b, required 100", {oBusy, oCall});
      end
      tick;
      checks++;
      if ({oCall, oDev, oAddr, oData} !== {2'b10, 8'h78, 8'h00, 8'hAE}) begin
         errors++; $display("FAIL wr_bus: got %b %h %h %h, required 10 78 00 ae", oCall, oDev, oAddr, oData);
      end
      iDataA = 8'h11;
      tick;
      checks++;
      if (oData !== 8'hAE) begin errors++; $display("FAIL wr_latched: got %h, required ae", oData); end
      iDone = 1'b1;
      tick;
      iDone = 1'b0;
      checks++;
      if ({oDoneA, oCall} !== 3'b000) begin
         errors++; $display("FAIL wr_capture: done/call got %b, required 000", {oDoneA, oCall});
      end
      tick;
      checks++;
      if ({oDoneA, oErrA} !== 2'b10) begin
         errors++; $display("FAIL wr_done: done/err got %b, required 10", {oDoneA, oErrA});
      end
      iCallA = CALL_NONE; iDataA = 8'h00;
      tick;
      n = 1;
      checks++;
      if (oDoneA !== 1'b0) begin errors++; $display("FAIL wr_done_single: got %b, required 0", oDoneA); end
      while (oBusy && n < 40) begin
         tick;
         n++;
      end
      checks++;
      if (n != GAP_C + 1) begin
         errors++; $display("FAIL wr_busy_fall: fell after %0d cycles, required %0d", n, GAP_C + 1);
      end
   endtask

   task automatic test_read_b;
      iCallB = CALL_RD; iAddrB = 8'h02; iDataB = 8'h33;
      tick;
      tick;
      checks++;
      if ({oCall, oDev, oAddr} !== {2'b01, 8'hA2, 8'h02}) begin
         errors++; $display("FAIL rd_bus: got %b %h %h, required 01 a2 02", oCall, oDev, oAddr);
      end
      tick;
      iData = 8'h59; iDone = 1'b1;
      tick;
      iData = 8'h00; iDone = 1'b0;
      tick;
      checks++;
      if ({oDoneB, oErrB} !== 2'b10) begin
         errors++; $display("FAIL rd_done: done/err got %b, required 10", {oDoneB, oErrB});
      end
      checks++;
      if (oDataB !== 8'h59) begin errors++; $display("FAIL rd_data_b: got %h, required 59", oDataB); end
      checks++;
      if (oDataA !== 8'h00) begin errors++; $display("FAIL rd_data_a: got %h, required 00", oDataA); end
      iCallB = CALL_NONE;
      wait_idle;
   endtask

   task automatic test_round_robin;
      logic [7:0] expDev [6];
      logic [1:0] expDone;
      int n;
      expDev = '{8'h78, 8'hA2, 8'h78, 8'hA2, 8'h78, 8'hA2};
      iCallA = CALL_WR; iAddrA = 8'h10; iDataA = 8'h01;
      iCallB = CALL_WR; iAddrB = 8'h20; iDataB = 8'h02;
      for (int t = 0; t < 6; t++) begin
         n = 0;
         while (oCall == CALL_NONE && n < 40) begin
            tick;
            n++;
         end
         checks++;
         if (oCall === CALL_NONE || oDev !== expDev[t]) begin
            errors++; $display("FAIL rr_grant_%0d: call %b dev %h, required dev %h", t, oCall, oDev, expDev[t]);
         end
         iDone = 1'b1;
         tick;
         iDone = 1'b0;
         tick;
         expDone = (t % 2 == 0) ? 2'b10 : 2'b01;
         checks++;
         if ({oDoneA, oDoneB} !== expDone) begin
            errors++; $display("FAIL rr_done_%0d: got %b, required %b", t, {oDoneA, oDoneB}, expDone);
         end
         if (t % 2 == 0) iCallA = CALL_NONE; else iCallB = CALL_NONE;
         tick;
         iCallA = CALL_WR;
         iCallB = CALL_WR;
      end
      iCallA = CALL_NONE;
      iCallB = CALL_NONE;
      wait_idle;
   endtask

   task automatic test_timeout;
      int n;
      int pulses;
      logic seen;
      iCallA = CALL_WR; iAddrA = 8'h05; iDataA = 8'h5A;
      tick;
      n = 1;
      seen = 1'b0;
      while (n < 300) begin
         tick;
         n++;
         if (oCall != CALL_NONE) seen = 1'b1;
         else if (seen) break;
      end
      checks++;
      if (n - 1 != 100) begin
         errors++; $display("FAIL tmo_drop: grant to call drop %0d cycles, required 100", n - 1);
      end
      tick;
      checks++;
      if ({oDoneA, oErrA} !== 2'b11) begin
         errors++; $display("FAIL tmo_done: done/err got %b, required 11", {oDoneA, oErrA});
      end
      iCallA = CALL_NONE;
      iData = 8'hEE; iDone = 1'b1;
      tick;
      iData = 8'h00; iDone = 1'b0;
      pulses = 0;
      repeat (30) begin
         tick;
         if (oDoneA || oDoneB) pulses++;
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL tmo_late_done: %0d pulses, required 0", pulses); end
      checks++;
      if (oDataA !== 8'h00) begin errors++; $display("FAIL tmo_data_a: got %h, required 00", oDataA); end
      wait_idle;
   endtask

   task automatic test_illegal;
      logic callSeen;
      int n;
      callSeen = 1'b0;
      iCallB = CALL_BAD;
      tick;
      if (oCall != CALL_NONE) callSeen = 1'b1;
      tick;
      if (oCall != CALL_NONE) callSeen = 1'b1;
      checks++;
      if ({oDoneB, oErrB} !== 2'b11) begin
         errors++; $display("FAIL ill_done: done/err got %b, required 11", {oDoneB, oErrB});
      end
      iCallB = CALL_NONE;
      n = 0;
      while (oBusy && n < 40) begin
         tick;
         n++;
         if (oCall != CALL_NONE) callSeen = 1'b1;
      end
      checks++;
      if (callSeen !== 1'b0) begin errors++; $display("FAIL ill_no_call: call seen %b, required 0", callSeen); end
      checks++;
      if (oDataB !== 8'h59) begin errors++; $display("FAIL ill_data_b: got %h, required 59", oDataB); end
   endtask

   task automatic test_reset_mid;
      int pulses;
      iCallA = CALL_WR; iAddrA = 8'h07; iDataA = 8'h70;
      tick;
      tick;
      checks++;
      if (oCall !== CALL_WR) begin errors++; $display("FAIL mid_call: got %b, required 10", oCall); end
      #2 RST_n = 1'b0;
      #1;
      checks++;
      if ({oCall, oBusy} !== 3'b000) begin
         errors++; $display("FAIL mid_async: call/busy got %b, required 000", {oCall, oBusy});
      end
      iCallA = CALL_NONE;
      tick;
      tick;
      RST_n = 1'b1;
      iDone = 1'b1;
      tick;
      iDone = 1'b0;
      pulses = 0;
      repeat (10) begin
         tick;
         if (oDoneA || oDoneB) pulses++;
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL mid_no_done: %0d pulses, required 0", pulses); end
      iCallA = CALL_RD; iAddrA = 8'h01;
      iCallB = CALL_RD; iAddrB = 8'h03;
      tick;
      tick;
      checks++;
      if ({oCall, oDev} !== {2'b01, 8'h78}) begin
         errors++; $display("FAIL mid_tie_a: call/dev got %b %h, required 01 78", oCall, oDev);
      end
      iData = 8'hC3; iDone = 1'b1;
      tick;
      iData = 8'h00; iDone = 1'b0;
      tick;
      checks++;
      if ({oDoneA, oDoneB, oDataA} !== {2'b10, 8'hC3}) begin
         errors++; $display("FAIL mid_read_a: done %b data %h, required 10 c3", {oDoneA, oDoneB}, oDataA);
      end
      iCallA = CALL_NONE;
      iCallB = CALL_NONE;
      wait_idle;
   endtask

   initial begin
      test_reset;
      test_write_a;
      test_read_b;
      test_round_robin;
      test_timeout;
      test_illegal;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "global time limit");
   end

endmodule

// File: doc/iic_share_arb.md
Name: iic_share_arb

Overview:
- Arbiter/sequencer that shares one `iic` byte-transfer core between two independent caller modules.
  - Requester A is the OLED controller.
  - Requester B is the PCF8563 RTC controller.
- Presents the core's call/done handshake to each requester as if it owned the bus.
- Inserts device addressing, a round-robin grant, a bus-free gap and a watchdog timeout.
- Sits between the caller control modules and the single `iic` instance in the display top level.

Parameters:
- DEV_A, 8'h78, 8-bit IIC device write address driven on oDev while A is granted.
- DEV_B, 8'hA2, 8-bit IIC device write address driven on oDev while B is granted.
- GAP, 16, idle cycles forced between consecutive core transactions (legal range 2..255).
- TIMEOUT, 20'd1_000_000, cycles allowed for core iDone before abort (must be >= 1).

Ports:
- CLOCK  in  1  system clock; all logic on the rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- iCallA  in  2  requester A call: 2'b10 = write, 2'b01 = read, held until oDoneA.
- iAddrA  in  8  requester A register/word address.
- iDataA  in  8  requester A write byte.
- oDoneA  out  1  one-cycle completion pulse to A.
- oErrA  out  1  valid with oDoneA: 1 = timeout or illegal call.
- oDataA  out  8  read byte for A, updated only on A's successful read done.
- iCallB, iAddrB, iDataB, oDoneB, oErrB, oDataB: same as A, for requester B.
- oCall  out  2  call to the iic core (same encoding).
- oDev  out  8  device address to the core.
- oAddr  out  8  register address to the core.
- oData  out  8  write byte to the core.
- iDone  in  1  one-cycle done pulse from the core.
- iData  in  8  read byte from the core, valid in the iDone cycle.
- oBusy  out  1  high from grant until the end of GAP.

Behaviour:
- Reset state (asynchronous, any time): state = IDLE, last_grant = B (so A wins the first tie).
  - Outputs: oCall = 0, oDev/oAddr/oData = 0, all oDone/oErr = 0, oDataA/oDataB = 0, oBusy = 0, watchdog = 0.
  - Reset mid-transaction drops oCall immediately. No done pulse is issued afterwards.
- Request: a requester is requesting when its iCall != 2'b00.
- IDLE:
  - Neither requesting: stay in IDLE.
  - Exactly one requesting: grant it.
  - Both requesting: grant the one not in last_grant (round-robin).
  - On grant: latch call, address, data and DEV_x into registers; set last_grant; go to CALL. oBusy rises in the next cycle.
- Illegal call 2'b11 at grant:
  - No core call is issued.
  - Go directly to FINISH with err = 1.
- CALL:
  - oCall drives the latched call, held stable; watchdog counts up.
  - On iDone = 1: capture iData if the call was a read; drop oCall next cycle; go to FINISH with err = 0.
  - If the watchdog reaches TIMEOUT-1 without iDone: drop oCall; go to FINISH with err = 1.
- FINISH (1 cycle):
  - Pulse oDone of the granted requester with its oErr.
  - Update that requester's oData only when read and err = 0.
  - Go to GAP.
- GAP:
  - Counts GAP cycles, then returns to IDLE with oBusy = 0.
  - Requesters must deassert iCall within GAP-1 cycles after oDone. A call still held at IDLE is treated as a new request.
- Latency: grant registers 1 cycle after the request is seen in IDLE.
  - Uncontested request to oCall asserted: 2 cycles.
  - iDone to oDoneX: 2 cycles (capture cycle, then FINISH).
- Requester inputs changing while granted are ignored, because the values are latched at grant.
- iDone outside CALL is ignored.
- A late iDone after a timeout is ignored.
- No starvation: under continuous demand from both, grants strictly alternate.

Decomposition:
- Shared package `iic_share_pkg`:
  - Call encodings CALL_NONE = 2'b00, CALL_RD = 2'b01, CALL_WR = 2'b10.
  - State encodings IDLE, CALL, FINISH, GAP.
- One natural sub-module: `iic_share_wdog`, a loadable up-counter giving the timeout and gap counts (clear, enable, terminal-count flag).
- Grant logic and the FSM stay in the top module.

Test Plan:
- Single write from A (iCallA = 10, iAddrA = 8'h00, iDataA = 8'hAE):
  - oCall = 10, oDev = 8'h78, oAddr = 00, oData = AE.
  - Core iDone causes oDoneA to pulse 2 cycles later with oErrA = 0.
  - oBusy falls GAP + 1 cycles after oDoneA.
- Read from B (iCallB = 01, iAddrB = 8'h02), core returns iData = 8'h59:
  - oDev = 8'hA2.
  - oDataB = 8'h59 on oDoneB; oDataA unchanged.
- Both requesters calling every idle cycle for 6 transactions: grant order is A, B, A, B, A, B (first tie goes to A after reset).
- Core never answers, with TIMEOUT = 100:
  - oCall drops after 100 cycles; oDoneA pulses with oErrA = 1.
  - An iDone injected afterwards produces no extra done pulse.
- Illegal iCallB = 11:
  - oCall stays 00 throughout.
  - oDoneB pulses with oErrB = 1, 2 cycles after the grant.
- RST_n pulled low during CALL:
  - oCall = 0 and oBusy = 0 immediately (asynchronous).
  - No oDone pulses after release.
  - After release, the next tie is granted to A.
